nco_cordic_phase_det: RTL and testbench
=======================================

# nco_cordic_phase_det

Receive-side counterpart of the NCO. Takes signed sine/cosine sample pairs in NCO output format and recovers the instantaneous phase word in NCO phase-accumulator units (2^apr = 2π). Also returns the phase increment between consecutive valid samples, which equals the NCO `phi_inc` when the input comes from an NCO. Implemented as a fully pipelined CORDIC vectoring engine with one sample per enabled clock; used in the spoofer's loopback and carrier-tracking paths.

## Interface
- `mpr`, 18: input sample width, two's complement.
- `apr`, 32: phase / increment word width; ≤ 32.
- `niter`, 16: CORDIC micro-rotation stages, 8..24.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `clken` in 1: global enable; low freezes every register.
- `in_valid` in 1: qualifies `fsin_i`/`fcos_i` on enabled cycles.
- `fsin_i` in mpr: sine sample, signed.
- `fcos_i` in mpr: cosine sample, signed.
- `phase_o` out apr: unsigned phase = atan2(fsin_i, fcos_i)·2^apr/2π mod 2^apr.
- `mag_o` out mpr+1: unsigned vector magnitude × CORDIC gain (≈1.6468), not normalised.
- `phi_inc_o` out apr: phase_o(current) − phase_o(previous valid), mod 2^apr.
- `out_valid` out 1: `phase_o`/`mag_o` valid.
- `freq_valid` out 1: `phi_inc_o` valid; requires two valid outputs since reset.

## Operation
- Internal datapath widths:
  - x/y: mpr+2 bits, signed; guards against gain growth and negation of −2^(mpr−1).
  - z: apr bits, wraps mod 2^apr.
- Stage 0, pre-rotation:
  - If `fcos_i` < 0: x=−cos, y=−sin, z=2^(apr−1).
  - Else: x=cos, y=sin, z=0.
  - Zero flag = (sin==0 && cos==0).
- Stage i, i = 0..niter−1:
  - If y ≥ 0: x+=y>>>i, y−=x>>>i, z+=atan_i.
  - Else: x−=y>>>i, y+=x>>>i, z−=atan_i.
  - Shifts are arithmetic and use the previous-stage values.
- Arctan constants:
  - atan_i = round(atan(2^−i)·2^32/2π), held as a 24-entry 32-bit constant table.
  - For apr < 32, each entry is right-shifted by 32−apr with rounding.
- Output stage:
  - phase_o = z; mag_o = x[mpr:0].
  - If the zero flag is set, phase_o=0 and mag_o=0.
  - phi_inc_o = z − z_prev mod 2^apr. z_prev is held in a register updated only on valid outputs.
  - Input gaps (in_valid low) do not reset z_prev; phi_inc_o spans the gap.
- freq_valid:
  - Sticky "have previous" flag, set on the first valid output after reset.
  - freq_valid = out_valid && flag, where flag is the value before that output.
- Valid pipeline: a 1-bit shift register of niter+2 stages carries in_valid and the zero flag alongside the data.
- Invalid samples still flow through the datapath. Their outputs are don't-care, except that out_valid=0 and z_prev is not updated.
- Accuracy: |phase_o error| ≤ 2^(apr−niter+1) LSB for input magnitude ≥ 2^(mpr−4).

## Timing
- Reset, asynchronous on `reset_n` low:
  - phase_o, mag_o, phi_inc_o, z_prev = 0.
  - out_valid = 0, freq_valid = 0, have-previous flag = 0.
  - All pipeline valid bits = 0.
- Latency: a sample accepted on enabled cycle N appears with out_valid=1 on enabled cycle N+niter+2 (18 for defaults).
- Throughput: one sample per enabled cycle, no backpressure.
- `clken`=0:
  - All registers hold, including outputs and out_valid.
  - Latency counts enabled cycles only.
- Reset mid-stream:
  - In-flight samples are discarded.
  - The first post-reset valid output has freq_valid=0.
- Wrap-around:
  - Phase crossing 2^apr−1 → 0 yields a small positive phi_inc_o.
  - A negative rotation yields a two's-complement value near 2^apr.

## Test plan
- Cardinal angles, apr=32, tolerance ±2^17 LSB on phase:
  - (cos,sin)=(131071,0) → phase_o≈0x00000000, mag_o≈215855.
  - (0,131071) → ≈0x40000000.
  - (−131071,0) → ≈0x80000000.
  - (0,−131071) → ≈0xC0000000.
  - Each output has out_valid exactly 18 cycles after its input.
- Zero input (0,0) → phase_o=0, mag_o=0, out_valid=1.
- Continuous NCO-generated stream with phi_inc=0x01000000, amplitude 131071:
  - phi_inc_o ≈ 0x01000000 ±2^18.
  - freq_valid low on the first output, high on every later output.
- Wrap pair: phases 0xFF000000 then 0x01000000 → phi_inc_o ≈ 0x02000000. Reverse order → ≈0xFE000000.
- clken toggled 50% randomly with in_valid gaps:
  - Output sequence identical to the unstalled run, counting enabled cycles.
  - phi_inc_o across a gap = difference of the bracketing valid phases.
- reset_n pulsed low mid-stream:
  - All outputs go to 0 immediately; the in-flight samples produce no out_valid.
  - The next valid output has freq_valid=0.

Source files
------------

// File: rtl/nco_cordic_phase_det.sv
// CORDIC vectoring phase detector: recovers NCO phase, magnitude and
// per-sample phase increment from signed sine/cosine pairs.
`timescale 1ns/1ps
module nco_cordic_phase_det #(
  parameter int mpr   = 18,
  parameter int apr   = 32,
  parameter int niter = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           in_valid,
  input  logic [mpr-1:0] fsin_i,
  input  logic [mpr-1:0] fcos_i,
  output logic [apr-1:0] phase_o,
  output logic [mpr:0]   mag_o,
  output logic [apr-1:0] phi_inc_o,
  output logic           out_valid,
  output logic           freq_valid
);

  localparam int W  = mpr + 2;
  localparam int SH = 32 - apr;

  localparam logic [31:0] ATAN [24] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
  };

  // Table is in 32-bit turn units; narrower phase words round it down.
  function automatic logic [apr-1:0] atan_c(input logic [4:0] i);
    logic [32:0] t;
    t = {1'b0, ATAN[i]} + ((33'd1 << SH) >> 1);
    t = t >> SH;
    return t[apr-1:0];
  endfunction

  logic signed [W-1:0] x_q [niter+1];
  logic signed [W-1:0] y_q [niter+1];
  logic [apr-1:0]      z_q [niter+1];
  logic signed [W-1:0] x_n [niter];
  logic signed [W-1:0] y_n [niter];
  logic [apr-1:0]      z_n [niter];
  logic [niter:0]      v_q;
  logic [niter:0]      zf_q;

  logic signed [W-1:0] cos_e, sin_e;
  logic signed [W-1:0] x0, y0;
  logic [apr-1:0]      z0;
  logic                zf0;

  assign cos_e = {{2{fcos_i[mpr-1]}}, fcos_i};
  assign sin_e = {{2{fsin_i[mpr-1]}}, fsin_i};
  assign zf0   = (fsin_i == '0) && (fcos_i == '0);

  // Fold the left half-plane onto the right so the rotations converge.
  always_comb begin
    x0 = cos_e;
    y0 = sin_e;
    z0 = '0;
    if (cos_e[W-1]) begin
      x0 = -cos_e;
      y0 = -sin_e;
      z0 = {1'b1, {(apr-1){1'b0}}};
    end
  end

  always_comb begin
    for (int i = 0; i < niter; i++) begin
      if (!y_q[i][W-1]) begin
        x_n[i] = x_q[i] + (y_q[i] >>> i);
        y_n[i] = y_q[i] - (x_q[i] >>> i);
        z_n[i] = z_q[i] + atan_c(5'(i));
      end else begin
        x_n[i] = x_q[i] - (y_q[i] >>> i);
        y_n[i] = y_q[i] + (x_q[i] >>> i);
        z_n[i] = z_q[i] - atan_c(5'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= niter; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      v_q  <= '0;
      zf_q <= '0;
    end else if (clken) begin
      x_q[0]  <= x0;
      y_q[0]  <= y0;
      z_q[0]  <= z0;
      v_q[0]  <= in_valid;
      zf_q[0] <= zf0;
      for (int i = 0; i < niter; i++) begin
        x_q[i+1] <= x_n[i];
        y_q[i+1] <= y_n[i];
        z_q[i+1] <= z_n[i];
      end
      v_q[niter:1]  <= v_q[niter-1:0];
      zf_q[niter:1] <= zf_q[niter-1:0];
    end
  end

  logic [apr-1:0] ph_n;
  logic [mpr:0]   mag_n;
  logic [apr-1:0] z_prev;
  logic           have_prev;
  logic           v_end;

  assign v_end = v_q[niter];
  assign ph_n  = zf_q[niter] ? '0 : z_q[niter];

  always_comb begin
    mag_n = x_q[niter][mpr:0];
    if (zf_q[niter] || x_q[niter][W-1]) mag_n = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_o    <= '0;
      mag_o      <= '0;
      phi_inc_o  <= '0;
      out_valid  <= 1'b0;
      freq_valid <= 1'b0;
      z_prev     <= '0;
      have_prev  <= 1'b0;
    end else if (clken) begin
      phase_o    <= ph_n;
      mag_o      <= mag_n;
      phi_inc_o  <= ph_n - z_prev;
      out_valid  <= v_end;
      freq_valid <= v_end && have_prev;
      if (v_end) begin
        z_prev    <= ph_n;
        have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nco_cordic_phase_det.sv
// Scoreboard bench for nco_cordic_phase_det: sine/cosine from a phase
// model, expected phase/mag/increment queued and matched at the output.
`timescale 1ns/1ps
module tb_nco_cordic_phase_det;
  localparam int MPR = 18;
  localparam int APR = 32;
  localparam int NITER = 16;
  localparam int LAT = NITER + 2;
  localparam real TWO_PI = 6.283185307179586;

  logic clk = 1'b0;
  logic reset_n, clken, in_valid;
  logic [MPR-1:0] fsin_i, fcos_i;
  logic [APR-1:0] phase_o, phi_inc_o;
  logic [MPR:0] mag_o;
  logic out_valid, freq_valid;

  nco_cordic_phase_det #(.mpr(MPR), .apr(APR), .niter(NITER)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .in_valid(in_valid), .fsin_i(fsin_i), .fcos_i(fcos_i),
    .phase_o(phase_o), .mag_o(mag_o), .phi_inc_o(phi_inc_o),
    .out_valid(out_valid), .freq_valid(freq_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ph;
    longint ph_tol;
    longint mag;
    longint mag_tol;
    logic [31:0] inc;
    bit fv;
    int cin;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int ecnt = 0;
  bit en_last = 1'b0;
  bit m_have = 1'b0;
  logic [31:0] m_prev = '0;
  real kgain;

  task automatic chk(input string tag, input longint got,
                     input longint exp, input longint tol,
                     input bit wrap);
    longint d;
    total++;
    d = got - exp;
    if (wrap) d = longint'($signed(d[31:0]));
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h tol=%0d", tag, got, exp, tol);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  always @(posedge clk) begin
    en_last <= reset_n && clken;
    if (reset_n && clken) ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (en_last && reset_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexp", 1, 0, 0, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("lat", ecnt - e.cin, LAT, 0, 1'b0);
        chk("ph", phase_o, e.ph, e.ph_tol, 1'b1);
        chk("mag", mag_o, e.mag, e.mag_tol, 1'b0);
        chk("fv", freq_valid, e.fv, 0, 1'b0);
        if (e.fv) chk("inc", phi_inc_o, e.inc, 1 << 18, 1'b1);
      end
    end
  end

  task automatic send(input logic [31:0] p, input int amp,
                      input bit v, input bit rnd_en);
    exp_t e;
    real a, r;
    int c, s;
    r = p;
    a = TWO_PI * r / 4294967296.0;
    c = rnd(amp * $cos(a));
    s = rnd(amp * $sin(a));
    do begin
      @(negedge clk);
      clken = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      fcos_i = c[MPR-1:0];
      fsin_i = s[MPR-1:0];
    end while (!clken);
    if (v) begin
      e.ph = (c == 0 && s == 0) ? 32'h0 : p;
      e.ph_tol = (c == 0 && s == 0) ? 0 : (1 << 17);
      e.mag = (c == 0 && s == 0) ? 0 : longint'(rnd(amp * kgain));
      e.mag_tol = (c == 0 && s == 0) ? 0 : 128;
      e.fv = m_have;
      e.inc = e.ph - m_prev;
      e.cin = ecnt;
      m_prev = e.ph;
      m_have = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) begin
      @(negedge clk);
      clken = 1'b1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("drain", sb.size(), 0, 0, 1'b0);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_ph", phase_o, 0, 0, 1'b0);
    chk("rst_mag", mag_o, 0, 0, 1'b0);
    chk("rst_inc", phi_inc_o, 0, 0, 1'b0);
    chk("rst_ov", out_valid, 0, 0, 1'b0);
    chk("rst_fv", freq_valid, 0, 0, 1'b0);
    sb.delete();
    m_have = 1'b0;
    m_prev = '0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    clken = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    kgain = 1.0;
    for (int i = 0; i < NITER; i++)
      kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    reset_n = 1'b0;
    clken = 1'b0;
    in_valid = 1'b0;
    fsin_i = '0;
    fcos_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("init_ph", phase_o, 0, 0, 1'b0);
    chk("init_mag", mag_o, 0, 0, 1'b0);
    chk("init_inc", phi_inc_o, 0, 0, 1'b0);
    chk("init_ov", out_valid, 0, 0, 1'b0);
    chk("init_fv", freq_valid, 0, 0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    clken = 1'b1;

    send(32'h00000000, 131071, 1'b1, 1'b0);
    send(32'h40000000, 131071, 1'b1, 1'b0);
    send(32'h80000000, 131071, 1'b1, 1'b0);
    send(32'hC0000000, 131071, 1'b1, 1'b0);
    send(32'h12345678, 0, 1'b1, 1'b0);
    send(32'h20000000, 131071, 1'b1, 1'b0);
    drain();

    pulse_reset(2);
    for (int k = 0; k < 40; k++)
      send(32'h00800000 + 32'(k) * 32'h01000000, 131071, 1'b1, 1'b0);
    send(32'hFF000000, 131071, 1'b1, 1'b0);
    send(32'h01000000, 131071, 1'b1, 1'b0);
    send(32'hFF000000, 131071, 1'b1, 1'b0);
    drain();

    for (int k = 0; k < 80; k++)
      send($urandom, ($urandom_range(0, 1) != 0) ? 131071 : 40000,
           $urandom_range(0, 9) < 7, 1'b1);
    drain();

    for (int k = 0; k < 8; k++)
      send(32'h10000000 * 32'(k), 131071, 1'b1, 1'b0);
    pulse_reset(3);
    repeat (30) @(negedge clk);
    send(32'h30000000, 131071, 1'b1, 1'b0);
    send(32'h38000000, 131071, 1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
